// File: rtl/gen_bus_mem_arbiter.sv
// rtl/gen_bus_mem_arbiter.sv - shares one generic bus between icache and dcache memory ports
module gen_bus_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_ren,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_busy,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [DATA_W/8-1:0] d_byte_en,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_busy,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [DATA_W-1:0]   out_wdata,
    output logic                out_ren,
    output logic                out_wen,
    output logic [DATA_W/8-1:0] out_byte_en,
    input  logic [DATA_W-1:0]   out_rdata,
    input  logic                out_busy,
    output logic                grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       req_i, req_d, i_forced;

    assign req_i    = i_ren;
    assign req_d    = d_ren | d_wen;
    // I wins a tie only once D has been granted MAX_STARVE times in a row over it
    assign i_forced = req_i && (starve_cnt == STARVE_LIMIT);
    assign grant_d  = (state == GRANT_D);

    // State and starvation counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Arbitration, owner passthrough and completion/abandon detection
    always_comb begin
        state_nxt   = state;
        starve_nxt  = starve_cnt;
        out_addr    = '0;
        out_wdata   = '0;
        out_ren     = 1'b0;
        out_wen     = 1'b0;
        out_byte_en = '0;
        i_rdata     = '0;
        i_busy      = 1'b1;
        d_rdata     = '0;
        d_busy      = 1'b1;
        case (state)
            IDLE: begin
                if (req_d && !i_forced) begin
                    state_nxt = GRANT_D;
                    if (!req_i)
                        starve_nxt = 4'd0;
                    else if (starve_cnt < STARVE_LIMIT)
                        starve_nxt = starve_cnt + 4'd1;
                end else if (req_i) begin
                    state_nxt  = GRANT_I;
                    starve_nxt = 4'd0;
                end
            end
            GRANT_I: begin
                out_addr    = i_addr;
                out_ren     = i_ren;
                out_byte_en = '1;
                i_rdata     = out_rdata;
                i_busy      = out_busy;
                if (!req_i || !out_busy)
                    state_nxt = IDLE;
            end
            GRANT_D: begin
                out_addr    = d_addr;
                out_wdata   = d_wdata;
                out_ren     = d_ren;
                out_wen     = d_wen;
                out_byte_en = d_byte_en;
                d_rdata     = out_rdata;
                d_busy      = out_busy;
                if (!req_d || !out_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
